// File: rtl/uart_cmd_mstr_gen.sv
// Host-side UART command master: sends a CMD_BYTES-wide command MSB byte first and collects resp_len bytes.
// Optional macro RESP_TIMEOUT_EN adds a per-byte response timeout; without it WAIT_RESP waits indefinitely.
module uart_cmd_mstr_gen #(
    parameter int CMD_BYTES   = 3,
    parameter int BAUD_DIV    = 108,
    parameter int MAX_RESP    = 512,
    parameter int TIMEOUT_CYC = 1048576,
    localparam int RLW        = $clog2(MAX_RESP + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*CMD_BYTES-1:0] cmd,
    input  logic [RLW-1:0]         resp_len,
    input  logic                   send_cmd,
    output logic                   busy,
    output logic                   cmd_sent,
    output logic                   TX,
    input  logic                   RX,
    output logic [7:0]             resp,
    output logic                   resp_vld,
    output logic [RLW-1:0]         resp_cnt,
    output logic                   resp_rdy,
    input  logic                   clr_resp_rdy,
    output logic                   frame_err,
    output logic                   timeout
);
    localparam int CMD_W = 8 * CMD_BYTES;
    localparam int BW    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int BYW   = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]  HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BYW-1:0] BYTE_LAST = BYW'(CMD_BYTES - 1);
    localparam logic [RLW-1:0] LEN_MAX   = RLW'(MAX_RESP);
    localparam logic [RLW-1:0] CNT_ONE   = RLW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_tx;
    logic               r_busy;
    logic               r_cmd_sent;
    logic [7:0]         r_resp;
    logic               r_resp_vld;
    logic [RLW-1:0]     r_resp_cnt;
    logic               r_resp_rdy;
    logic               r_frame_err;
    logic [RLW-1:0]     r_len;
    logic [CMD_W-1:0]   r_cmd_sh;
    logic [BW-1:0]      r_tx_baud;
    logic [3:0]         r_tx_bit;
    logic [BYW-1:0]     r_tx_byte;

    logic               r_rx_s1;
    logic               r_rx_s2;
    logic               r_rx_prev;
    logic               r_rx_busy;
    logic [BW-1:0]      r_rx_cnt;
    logic [3:0]         r_rx_bit;
    logic [7:0]         r_rx_sh;

    logic [RLW-1:0]     w_len_clamped;
    logic [7:0]         w_cur_byte;
    logic               w_rx_done;

`ifdef RESP_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYC - 1);
    logic [TOW-1:0]     r_to_cnt;
    logic               r_timeout;
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign TX        = r_tx;
    assign busy      = r_busy;
    assign cmd_sent  = r_cmd_sent;
    assign resp      = r_resp;
    assign resp_vld  = r_resp_vld;
    assign resp_cnt  = r_resp_cnt;
    assign resp_rdy  = r_resp_rdy;
    assign frame_err = r_frame_err;

    assign w_cur_byte = r_cmd_sh[CMD_W-1 -: 8];
    assign w_rx_done  = r_rx_busy && (r_rx_bit == 4'd9) && (r_rx_cnt == BAUD_LAST);

    // Oversized response lengths are limited to MAX_RESP
    always_comb begin
        w_len_clamped = resp_len;
        if (resp_len > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end else begin
            w_len_clamped = resp_len;
        end
    end

    // Free-running receiver: falling edge, half-bit glitch check, then centre sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_bit  <= 4'd0;
            r_rx_sh   <= 8'h00;
        end else begin
            r_rx_s1   <= RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= '0;
                    r_rx_bit  <= 4'd0;
                end
            end else if (r_rx_bit == 4'd0) begin
                if (r_rx_cnt == HALF_LAST) begin
                    r_rx_cnt <= '0;
                    if (r_rx_s2) begin
                        r_rx_busy <= 1'b0;
                    end else begin
                        r_rx_bit <= 4'd1;
                    end
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end else if (r_rx_cnt == BAUD_LAST) begin
                r_rx_cnt <= '0;
                if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                end else begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 4'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end

    // Command FSM: serialises the command and collects response bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_cmd_sent  <= 1'b0;
            r_resp      <= 8'h00;
            r_resp_vld  <= 1'b0;
            r_resp_cnt  <= '0;
            r_resp_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
            r_len       <= '0;
            r_cmd_sh    <= '0;
            r_tx_baud   <= '0;
            r_tx_bit    <= 4'd0;
            r_tx_byte   <= '0;
`ifdef RESP_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_cmd_sent <= 1'b0;
            r_resp_vld <= 1'b0;
            r_busy     <= (r_state != ST_IDLE);
            if (clr_resp_rdy) begin
                r_resp_rdy <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    // busy lingers one cycle after return to IDLE, which also blocks re-accept
                    if (send_cmd && !r_busy) begin
                        r_state     <= ST_SEND;
                        r_busy      <= 1'b1;
                        r_cmd_sh    <= cmd;
                        r_len       <= w_len_clamped;
                        r_resp_cnt  <= '0;
                        r_resp_rdy  <= 1'b0;
                        r_frame_err <= 1'b0;
                        r_tx        <= 1'b0;
                        r_tx_baud   <= '0;
                        r_tx_bit    <= 4'd0;
                        r_tx_byte   <= '0;
`ifdef RESP_TIMEOUT_EN
                        r_timeout   <= 1'b0;
`endif
                    end
                end
                ST_SEND: begin
                    if (r_tx_baud == BAUD_LAST) begin
                        r_tx_baud <= '0;
                        if (r_tx_bit == 4'd9) begin
                            if (r_tx_byte == BYTE_LAST) begin
                                r_cmd_sent <= 1'b1;
                                if (r_len == '0) begin
                                    r_resp_rdy <= 1'b1;
                                    r_state    <= ST_IDLE;
                                end else begin
                                    r_state    <= ST_WAIT;
                                end
`ifdef RESP_TIMEOUT_EN
                                r_to_cnt   <= '0;
`endif
                            end else begin
                                r_tx_byte <= r_tx_byte + 1'b1;
                                r_cmd_sh  <= r_cmd_sh << 8;
                                r_tx_bit  <= 4'd0;
                                r_tx      <= 1'b0;
                            end
                        end else if (r_tx_bit == 4'd8) begin
                            r_tx_bit <= 4'd9;
                            r_tx     <= 1'b1;
                        end else begin
                            r_tx     <= w_cur_byte[r_tx_bit[2:0]];
                            r_tx_bit <= r_tx_bit + 4'd1;
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_rx_done) begin
                        r_resp     <= r_rx_sh;
                        r_resp_vld <= 1'b1;
                        r_resp_cnt <= r_resp_cnt + CNT_ONE;
                        if (!r_rx_s2) begin
                            r_frame_err <= 1'b1;
                        end
                        if ((r_resp_cnt + CNT_ONE) == r_len) begin
                            r_resp_rdy <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
`ifdef RESP_TIMEOUT_EN
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_mstr_gen.sv
// Self-checking bench for uart_cmd_mstr_gen: TX frames decoded at bit centres, RX driven by a UART line model,
// response bytes scoreboarded against expectations computed from the command/length rules.
module tb_uart_cmd_mstr_gen;
    localparam int CB  = 3;
    localparam int BD  = 8;
    localparam int MR  = 512;
    localparam int TC  = 1000;
    localparam int RLW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [23:0]     cmd = 24'h0;
    logic [RLW-1:0]  resp_len = '0;
    logic            send_cmd = 1'b0;
    logic            RX = 1'b1;
    logic            clr_resp_rdy = 1'b0;
    logic            busy, cmd_sent, TX, resp_vld, resp_rdy, frame_err, timeout;
    logic [7:0]      resp;
    logic [RLW-1:0]  resp_cnt;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;

    logic [7:0] q_resp[$];
    int         q_cnt[$];
    logic       q_rdy[$];
    int         q_time[$];

    uart_cmd_mstr_gen #(.CMD_BYTES(CB), .BAUD_DIV(BD), .MAX_RESP(MR), .TIMEOUT_CYC(TC)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .resp_len(resp_len), .send_cmd(send_cmd),
        .busy(busy), .cmd_sent(cmd_sent), .TX(TX), .RX(RX), .resp(resp), .resp_vld(resp_vld),
        .resp_cnt(resp_cnt), .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy),
        .frame_err(frame_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard capture of every delivered response byte
    always @(negedge clk) begin
        if (resp_vld === 1'b1) begin
            q_resp.push_back(resp);
            q_cnt.push_back(int'(resp_cnt));
            q_rdy.push_back(resp_rdy);
            q_time.push_back(cyc_cnt);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        q_resp.delete(); q_cnt.delete(); q_rdy.delete(); q_time.delete();
    endtask

    task automatic start_cmd(input logic [23:0] c, input logic [RLW-1:0] l);
        @(negedge clk);
        cmd = c; resp_len = l; send_cmd = 1'b1;
        @(posedge clk);
        #1 send_cmd = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        RX = 1'b0; repeat (BD) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            RX = b[i]; repeat (BD) @(posedge clk); #1;
        end
        RX = stop; repeat (BD) @(posedge clk); #1;
        if (!stop) begin
            RX = 1'b1; repeat (BD) @(posedge clk); #1;
        end
        RX = 1'b1;
    endtask

    // Starts at the negedge after the accept edge; decodes TX at bit centres and records cmd_sent/busy timing
    task automatic tx_capture(input int inj_cyc, input logic [23:0] inj_cmd,
                              output logic [23:0] got, output bit framing_ok, output int sent_cyc,
                              output int sent_n, output logic rdy_at_sent, output logic busy_at_sent,
                              output logic busy_after);
        got = 24'h0; framing_ok = 1'b1; sent_cyc = -1; sent_n = 0;
        rdy_at_sent = 1'bx; busy_at_sent = 1'bx; busy_after = 1'bx;
        for (int c = 0; c < 244; c++) begin
            if ((c % BD) == BD / 2 && c < CB * 10 * BD) begin
                int j, b, p;
                j = c / BD; b = j / 10; p = j % 10;
                if (p == 0) framing_ok &= (TX === 1'b0);
                else if (p == 9) framing_ok &= (TX === 1'b1);
                else got[(CB - 1 - b) * 8 + p - 1] = TX;
            end
            if (cmd_sent === 1'b1) begin
                sent_n++; sent_cyc = c; rdy_at_sent = resp_rdy; busy_at_sent = busy;
            end
            if (c == CB * 10 * BD + 1) busy_after = busy;
            if (c == inj_cyc) begin send_cmd = 1'b1; cmd = inj_cmd; end
            if (c == inj_cyc + 1) send_cmd = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({TX, busy, cmd_sent, resp, resp_vld, resp_cnt, resp_rdy, frame_err, timeout} !==
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b",
                {TX, busy, cmd_sent, resp, resp_vld, resp_cnt, resp_rdy, frame_err, timeout},
                {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [23:0] got; bit ok; int sc, sn; logic ra, ba, bf;
        clear_q();
        start_cmd(24'h02_0000, 10'd1);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_accept got=%b exp=1", busy); end
        tx_capture(-10, 24'h0, got, ok, sc, sn, ra, ba, bf);
        checks++;
        if (got !== 24'h02_0000) begin failures++; $display("FAIL single_tx_cmd got=%h exp=020000", got); end
        checks++;
        if (!ok) begin failures++; $display("FAIL single_tx_framing got=%0d exp=1", ok); end
        checks++;
        if (sc !== CB * 10 * BD || sn !== 1) begin
            failures++; $display("FAIL single_cmd_sent got=cyc%0d/n%0d exp=cyc%0d/n1", sc, sn, CB * 10 * BD);
        end
        rx_byte(8'hA5, 1'b1);
        @(negedge clk);
        checks++;
        if (q_resp.size() !== 1) begin
            failures++; $display("FAIL single_vld_count got=%0d exp=1", q_resp.size());
        end else begin
            checks++;
            if ({q_resp[0], q_rdy[0]} !== {8'hA5, 1'b1} || q_cnt[0] !== 1) begin
                failures++;
                $display("FAIL single_resp got=%h/rdy%b/cnt%0d exp=a5/rdy1/cnt1", q_resp[0], q_rdy[0], q_cnt[0]);
            end
        end
        checks++;
        if ({busy, resp_rdy, resp_cnt} !== {1'b0, 1'b1, 10'd1}) begin
            failures++; $display("FAIL single_final got=%b exp=%b", {busy, resp_rdy, resp_cnt}, {1'b0, 1'b1, 10'd1});
        end
    endtask

    task automatic test_random_cmds();
        for (int it = 0; it < 4; it++) begin
            logic [23:0] c, got; bit ok; int sc, sn, n, inj; logic ra, ba, bf;
            logic [7:0] exp_b[$];
            c = 24'($urandom); n = $urandom_range(1, 4); inj = $urandom_range(10, 230);
            clear_q();
            start_cmd(c, RLW'(n));
            checks++;
            if ({resp_rdy, resp_cnt} !== 11'd0) begin
                failures++; $display("FAIL rand%0d_accept_clear got=%b exp=0", it, {resp_rdy, resp_cnt});
            end
            tx_capture(inj, ~c, got, ok, sc, sn, ra, ba, bf);
            checks++;
            if (got !== c || !ok) begin
                failures++; $display("FAIL rand%0d_tx got=%h/ok%0d exp=%h/ok1", it, got, ok, c);
            end
            checks++;
            if (sc !== CB * 10 * BD || sn !== 1 || ba !== 1'b1) begin
                failures++; $display("FAIL rand%0d_cmd_sent got=cyc%0d/n%0d/busy%b exp=cyc240/n1/busy1", it, sc, sn, ba);
            end
            for (int k = 0; k < n + (it % 2); k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_b.push_back(b);
                rx_byte(b, 1'b1);
            end
            @(negedge clk);
            checks++;
            if (q_resp.size() !== n) begin
                failures++; $display("FAIL rand%0d_vld_count got=%0d exp=%0d", it, q_resp.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (q_resp[k] !== exp_b[k] || q_cnt[k] !== k + 1 || q_rdy[k] !== (k == n - 1)) begin
                        failures++;
                        $display("FAIL rand%0d_byte%0d got=%h/cnt%0d/rdy%b exp=%h/cnt%0d/rdy%b",
                                 it, k, q_resp[k], q_cnt[k], q_rdy[k], exp_b[k], k + 1, (k == n - 1));
                    end
                end
            end
            checks++;
            if ({busy, resp_rdy, resp_cnt, resp} !== {1'b0, 1'b1, RLW'(n), exp_b[n - 1]}) begin
                failures++;
                $display("FAIL rand%0d_final got=%b exp=%b", it, {busy, resp_rdy, resp_cnt, resp},
                         {1'b0, 1'b1, RLW'(n), exp_b[n - 1]});
            end
            if (it == 0) begin
                clr_resp_rdy = 1'b1;
                @(negedge clk);
                clr_resp_rdy = 1'b0;
                checks++;
                if (resp_rdy !== 1'b0) begin failures++; $display("FAIL clr_resp_rdy got=%b exp=0", resp_rdy); end
            end
        end
    endtask

    task automatic test_resp_len_zero();
        logic [23:0] c, got; bit ok; int sc, sn; logic ra, ba, bf;
        c = 24'($urandom);
        start_cmd(c, 10'd0);
        tx_capture(-10, 24'h0, got, ok, sc, sn, ra, ba, bf);
        checks++;
        if (got !== c || !ok) begin failures++; $display("FAIL len0_tx got=%h exp=%h", got, c); end
        checks++;
        if (sc !== CB * 10 * BD || sn !== 1 || ra !== 1'b1) begin
            failures++; $display("FAIL len0_sent_rdy got=cyc%0d/n%0d/rdy%b exp=cyc240/n1/rdy1", sc, sn, ra);
        end
        checks++;
        if (ba !== 1'b1 || bf !== 1'b0) begin
            failures++; $display("FAIL len0_busy got=at%b/next%b exp=at1/next0", ba, bf);
        end
    endtask

    task automatic test_frame_err();
        logic [23:0] got; bit ok; int sc, sn; logic ra, ba, bf; logic [7:0] b2;
        b2 = 8'($urandom);
        clear_q();
        start_cmd(24'($urandom), 10'd2);
        tx_capture(-10, 24'h0, got, ok, sc, sn, ra, ba, bf);
        rx_byte(8'h3C, 1'b0);
        checks++;
        if (q_resp.size() !== 1 || frame_err !== 1'b1 || resp !== 8'h3C) begin
            failures++; $display("FAIL ferr_first got=n%0d/ferr%b/resp%h exp=n1/ferr1/resp3c", q_resp.size(), frame_err, resp);
        end
        rx_byte(b2, 1'b1);
        @(negedge clk);
        checks++;
        if (q_resp.size() !== 2 || frame_err !== 1'b1 || resp_rdy !== 1'b1 || resp_cnt !== 10'd2) begin
            failures++;
            $display("FAIL ferr_sticky got=n%0d/ferr%b/rdy%b/cnt%0d exp=n2/ferr1/rdy1/cnt2", q_resp.size(), frame_err, resp_rdy, resp_cnt);
        end
        clear_q();
        start_cmd(24'($urandom), 10'd1);
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
        tx_capture(-10, 24'h0, got, ok, sc, sn, ra, ba, bf);
        rx_byte(8'h5A, 1'b1);
        @(negedge clk);
        checks++;
        if (q_resp.size() !== 1 || resp !== 8'h5A || frame_err !== 1'b0) begin
            failures++; $display("FAIL ferr_after got=n%0d/%h/ferr%b exp=n1/5a/ferr0", q_resp.size(), resp, frame_err);
        end
    endtask

    // Requested length above MAX_RESP behaves as MAX_RESP
    task automatic test_dump();
        logic [23:0] c, got; bit ok; int sc, sn, errs; logic ra, ba, bf;
        c = 24'($urandom);
        clear_q();
        start_cmd(c, 10'd1023);
        tx_capture(-10, 24'h0, got, ok, sc, sn, ra, ba, bf);
        checks++;
        if (got !== c || !ok) begin failures++; $display("FAIL dump_tx got=%h exp=%h", got, c); end
        for (int i = 0; i < MR + 1; i++) begin
            logic [7:0] b;
            b = (i < MR) ? 8'(i % 256) : 8'hEE;
            rx_byte(b, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (q_resp.size() !== MR) begin
            failures++; $display("FAIL dump_vld_count got=%0d exp=%0d", q_resp.size(), MR);
        end else begin
            errs = 0;
            for (int i = 0; i < MR; i++) begin
                checks++;
                if (q_resp[i] !== 8'(i % 256) || q_cnt[i] !== i + 1 || q_rdy[i] !== (i == MR - 1)) begin
                    failures++;
                    if (errs < 5) $display("FAIL dump_byte%0d got=%h/cnt%0d/rdy%b exp=%h/cnt%0d/rdy%b",
                                           i, q_resp[i], q_cnt[i], q_rdy[i], 8'(i % 256), i + 1, (i == MR - 1));
                    errs++;
                end
            end
        end
        checks++;
        if ({busy, resp_rdy, resp_cnt, resp} !== {1'b0, 1'b1, 10'd512, 8'hFF}) begin
            failures++; $display("FAIL dump_final got=%b exp=%b", {busy, resp_rdy, resp_cnt, resp}, {1'b0, 1'b1, 10'd512, 8'hFF});
        end
    endtask

    task automatic test_timeout();
        logic [23:0] got; bit ok; int sc, sn, t; logic ra, ba, bf;
        clear_q();
        start_cmd(24'($urandom), 10'd2);
        tx_capture(-10, 24'h0, got, ok, sc, sn, ra, ba, bf);
        rx_byte(8'($urandom), 1'b1);
        checks++;
        if (q_resp.size() !== 1) begin failures++; $display("FAIL to_first_byte got=%0d exp=1", q_resp.size()); end
`ifdef RESP_TIMEOUT_EN
        t = -1;
        for (int k = 0; k < TC + 200 && t < 0; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) t = cyc_cnt;
        end
        checks++;
        if (q_time.size() < 1 || t < 0 || t - q_time[0] !== TC) begin
            failures++; $display("FAIL to_timing got=%0d exp=%0d", (t < 0 || q_time.size() < 1) ? -1 : t - q_time[0], TC);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({timeout, resp_rdy, busy} !== 3'b100) begin
            failures++; $display("FAIL to_final got=%b exp=100", {timeout, resp_rdy, busy});
        end
`else
        t = 0;
        repeat (TC + 200) @(negedge clk);
        checks++;
        if ({busy, timeout, resp_rdy, resp_cnt} !== {1'b1, 1'b0, 1'b0, 10'd1}) begin
            failures++; $display("FAIL to_disabled got=%b exp=%b", {busy, timeout, resp_rdy, resp_cnt}, {1'b1, 1'b0, 1'b0, 10'd1});
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] c, got; bit ok; int sc, sn; logic ra, ba, bf;
        start_cmd(24'($urandom), 10'd1);
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({TX, busy, cmd_sent, resp, resp_vld, resp_cnt, resp_rdy, frame_err, timeout} !==
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midrst_state got=%b exp=%b",
                {TX, busy, cmd_sent, resp, resp_vld, resp_cnt, resp_rdy, frame_err, timeout},
                {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0});
        end
        rst = 1'b0;
        @(negedge clk);
        c = 24'($urandom);
        clear_q();
        start_cmd(c, 10'd1);
        tx_capture(-10, 24'h0, got, ok, sc, sn, ra, ba, bf);
        checks++;
        if (got !== c || !ok || sc !== CB * 10 * BD) begin
            failures++; $display("FAIL midrst_recover_tx got=%h/cyc%0d exp=%h/cyc240", got, sc, c);
        end
        rx_byte(8'h77, 1'b1);
        @(negedge clk);
        checks++;
        if (q_resp.size() !== 1 || resp !== 8'h77 || resp_rdy !== 1'b1) begin
            failures++; $display("FAIL midrst_recover_resp got=n%0d/%h/rdy%b exp=n1/77/rdy1", q_resp.size(), resp, resp_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_random_cmds();
        test_resp_len_zero();
        test_frame_err();
        test_timeout();
        test_reset_mid_frame();
        test_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_cmd_mstr_gen.md
Name: uart_cmd_mstr_gen

Overview:
Parametrised host-side UART command master for the DSO digital core bench and bring-up fixture. It sends a CMD_BYTES-wide command MSB-byte first, then collects a variable number of response bytes (1 for ack/read, up to MAX_RESP for channel dump). Each received byte is streamed out with a valid pulse. Successor to the fixed 24-bit/1-byte-response master, with per-command response length, framing-error detection and optional response timeout.

Parameters:
CMD_BYTES, 3, bytes per command frame sequence (cmd width = 8*CMD_BYTES)
BAUD_DIV, 108, clk cycles per UART bit (>= 4)
MAX_RESP, 512, maximum response bytes per command
TIMEOUT_CYC, 1048576, idle clk cycles allowed between response bytes (used only with RESP_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd  in  8*CMD_BYTES  command; sampled on send_cmd
resp_len  in  RLW=$clog2(MAX_RESP+1)  expected response byte count; sampled on send_cmd
send_cmd  in  1  start pulse; ignored while busy
busy  out  1  high from send_cmd accept until IDLE re-entered
cmd_sent  out  1  1-cycle pulse at end of last TX stop bit
TX  out  1  serial out to DUT RX
RX  in  1  serial in from DUT TX (asynchronous)
resp  out  8  last received byte
resp_vld  out  1  1-cycle pulse per accepted response byte
resp_cnt  out  RLW  bytes accepted for current command
resp_rdy  out  1  level; all resp_len bytes received
clr_resp_rdy  in  1  clears resp_rdy
frame_err  out  1  sticky; stop bit sampled low
timeout  out  1  sticky; response timeout (0 without macro)

Behaviour:
- Reset (sync, rst=1 at clk edge): TX=1, busy=0, cmd_sent=0, resp=8'h00, resp_vld=0, resp_cnt=0, resp_rdy=0, frame_err=0, timeout=0, state IDLE. Reset mid-frame aborts immediately; TX high the next cycle.
- FSM: IDLE -> SEND on send_cmd (latch cmd, resp_len; clear resp_cnt, resp_rdy, frame_err, timeout). SEND -> WAIT_RESP after last stop bit, cmd_sent pulse that cycle. If latched resp_len==0: SEND -> IDLE, resp_rdy set with cmd_sent. WAIT_RESP -> IDLE when resp_cnt reaches resp_len (resp_rdy set on the same cycle as the final resp_vld), or on timeout.
- TX frame: start(0), 8 data LSB first, stop(1); each bit exactly BAUD_DIV clocks; bytes back-to-back, cmd[8*CMD_BYTES-1 -: 8] first. Frame length = CMD_BYTES*10*BAUD_DIV clocks from the cycle after send_cmd.
- RX: 2-flop synchroniser, idle-high. Falling edge starts a byte; re-sample at BAUD_DIV/2, abort as glitch if high. Data sampled every BAUD_DIV thereafter (bit centres); stop sampled at centre. resp/resp_vld update at stop sample. Stop==0: frame_err set, byte still delivered and counted. Receiver runs in all states; bytes completing outside WAIT_RESP are dropped (no resp_vld, no count).
- resp_cnt saturates at resp_len; bytes beyond it are dropped.
- clr_resp_rdy and resp_rdy set in the same cycle: set wins. send_cmd while busy: ignored, no state change. send_cmd in IDLE while resp_rdy=1: accepted, resp_rdy cleared.
- Width: resp_len > MAX_RESP treated as MAX_RESP.

Optional Feature:
RESP_TIMEOUT_EN: when defined, a counter in WAIT_RESP reloads on entry and on every resp_vld; on reaching TIMEOUT_CYC, timeout is set, resp_rdy stays 0, FSM -> IDLE. When undefined, WAIT_RESP waits indefinitely, no counter is synthesised, and timeout is tied 0.

Test Plan:
BAUD_DIV=8, cmd=24'h02_0000, resp_len=1, DUT-model returns 8'hA5 -> TX shows bytes 02,00,00 (240 clk total), cmd_sent pulse, one resp_vld with resp=A5, resp_rdy=1, resp_cnt=1.
Dump: resp_len=512, model returns 0..255 twice -> 512 resp_vld pulses in order, resp_rdy on the 512th, a 513th stray byte is dropped.
resp_len=0 -> resp_rdy and cmd_sent assert together, busy drops next cycle.
RX byte with stop bit 0 (value 8'h3C) -> resp=3C, resp_vld pulses, frame_err=1 until the next send_cmd.
RESP_TIMEOUT_EN, TIMEOUT_CYC=1000, resp_len=2, only one byte returned -> timeout=1 at 1000 cycles after the first byte, resp_rdy=0, busy=0. Without macro -> busy stays 1.
rst pulsed mid-second TX byte -> TX=1 next cycle, all outputs at reset values; a subsequent send_cmd completes normally.
